// File: rtl/qupls_decode_src_pipe.sv
// Register-map decode stage: maps raw source/destination fields per slot, finds
// intra-group producer slots, and holds the result behind a valid/ready handshake.
module qupls_decode_src_pipe #(
  parameter int unsigned WID  = 4,
  parameter int unsigned NSRC = 3,
  parameter int unsigned AW   = 9
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [1:0]                                   om,
  input  logic                                         flush,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [WID*NSRC*6-1:0]                        src_fld,
  input  logic [WID*NSRC-1:0]                          src_imm,
  input  logic [WID*6-1:0]                             dst_fld,
  input  logic [WID-1:0]                               dst_vld,
  input  logic [WID-1:0]                               regx,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [WID*NSRC*AW-1:0]                       src_reg,
  output logic [WID*AW-1:0]                            dst_reg,
  output logic [WID*NSRC-1:0]                          dep_vld,
  output logic [WID*NSRC*((WID > 1) ? $clog2(WID) : 1)-1:0] dep_slot,
  output logic [15:0]                                  stall_cnt
);

  localparam int unsigned SW = (WID > 1) ? $clog2(WID) : 1;
  localparam int unsigned NS = WID * NSRC;

  logic                 out_valid_q;
  logic [NS*AW-1:0]     src_reg_q, src_reg_d;
  logic [WID*AW-1:0]    dst_reg_q, dst_reg_d;
  logic [NS-1:0]        dep_vld_q, dep_vld_d;
  logic [NS*SW-1:0]     dep_slot_q, dep_slot_d;
  logic [15:0]          stall_cnt_q;
  logic                 accept;

  // Register 63 in the base bank aliases to a mode-specific register.
  function automatic logic [AW-1:0] map_reg(input logic [5:0] fld, input logic x,
                                            input logic [1:0] mode);
    logic [7:0] m;
    m = {1'b0, x, fld};
    if (m == 8'd63) m = 8'd65 + {6'd0, mode};
    return AW'(m);
  endfunction

  // Map every operand, then pick the latest earlier writer of each source.
  always_comb begin
    src_reg_d  = '0;
    dst_reg_d  = '0;
    dep_vld_d  = '0;
    dep_slot_d = '0;
    for (int j = 0; j < WID; j++) begin
      if (dst_vld[j])
        dst_reg_d[j*AW +: AW] = map_reg(dst_fld[j*6 +: 6], regx[j], om);
      for (int s = 0; s < NSRC; s++) begin
        if (!src_imm[j*NSRC+s])
          src_reg_d[(j*NSRC+s)*AW +: AW] =
            map_reg(src_fld[(j*NSRC+s)*6 +: 6], regx[j], om);
      end
    end
    for (int j = 0; j < WID; j++) begin
      for (int s = 0; s < NSRC; s++) begin
        for (int i = 0; i < WID; i++) begin
          if (i < j && dst_vld[i] && src_reg_d[(j*NSRC+s)*AW +: AW] != '0 &&
              dst_reg_d[i*AW +: AW] == src_reg_d[(j*NSRC+s)*AW +: AW]) begin
            dep_vld_d[j*NSRC+s]          = 1'b1;
            dep_slot_d[(j*NSRC+s)*SW +: SW] = SW'(i);
          end
        end
      end
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      src_reg_q   <= '0;
      dst_reg_q   <= '0;
      dep_vld_q   <= '0;
      dep_slot_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        src_reg_q   <= src_reg_d;
        dst_reg_q   <= dst_reg_d;
        dep_vld_q   <= dep_vld_d;
        dep_slot_q  <= dep_slot_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign src_reg   = src_reg_q;
  assign dst_reg   = dst_reg_q;
  assign dep_vld   = dep_vld_q;
  assign dep_slot  = dep_slot_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_qupls_decode_src_pipe.sv
// Random and directed stimulus for the decode stage, scored against a
// cycle-level reference model of the mapping, dependency and handshake rules.
module tb_qupls_decode_src_pipe;

  localparam int WID  = 4;
  localparam int NSRC = 3;
  localparam int AW   = 9;
  localparam int SW   = (WID > 1) ? $clog2(WID) : 1;
  localparam int NS   = WID * NSRC;

  logic                 clk = 1'b0;
  logic                 rst_n, flush, in_valid, out_ready;
  logic [1:0]           om;
  logic                 in_ready, out_valid;
  logic [NS*6-1:0]      src_fld;
  logic [NS-1:0]        src_imm;
  logic [WID*6-1:0]     dst_fld;
  logic [WID-1:0]       dst_vld, regx;
  logic [NS*AW-1:0]     src_reg;
  logic [WID*AW-1:0]    dst_reg;
  logic [NS-1:0]        dep_vld;
  logic [NS*SW-1:0]     dep_slot;
  logic [15:0]          stall_cnt;

  qupls_decode_src_pipe #(.WID(WID), .NSRC(NSRC), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .om(om), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .src_fld(src_fld), .src_imm(src_imm), .dst_fld(dst_fld),
    .dst_vld(dst_vld), .regx(regx), .out_valid(out_valid), .out_ready(out_ready),
    .src_reg(src_reg), .dst_reg(dst_reg), .dep_vld(dep_vld), .dep_slot(dep_slot),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Group under construction.
  int t_src [WID][NSRC];
  bit t_imm [WID][NSRC];
  int t_dst [WID];
  bit t_dvld[WID];
  bit t_regx[WID];

  // Reference model state.
  bit e_valid;
  int e_stall;
  int e_src [WID][NSRC];
  int e_dst [WID];
  bit e_dv  [WID][NSRC];
  int e_ds  [WID][NSRC];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int map_ref(input int fld, input bit x, input int mode);
    int r;
    r = (x ? 64 : 0) + fld;
    if (r == 63) r = 65 + mode;
    return r;
  endfunction

  function automatic int rand_fld();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return 5;
      3: return 10;
      4: return 62;
      default: return 63;
    endcase
  endfunction

  task automatic clear_group();
    for (int j = 0; j < WID; j++) begin
      t_dst[j] = 0; t_dvld[j] = 0; t_regx[j] = 0;
      for (int s = 0; s < NSRC; s++) begin t_src[j][s] = 0; t_imm[j][s] = 1; end
    end
  endtask

  task automatic rand_group();
    for (int j = 0; j < WID; j++) begin
      t_dst[j] = rand_fld(); t_dvld[j] = bit'($urandom_range(0, 3) != 0);
      t_regx[j] = bit'($urandom_range(0, 1));
      for (int s = 0; s < NSRC; s++) begin
        t_src[j][s] = rand_fld(); t_imm[j][s] = bit'($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic drive();
    for (int j = 0; j < WID; j++) begin
      dst_fld[j*6 +: 6] = 6'(t_dst[j]);
      dst_vld[j] = t_dvld[j];
      regx[j]    = t_regx[j];
      for (int s = 0; s < NSRC; s++) begin
        src_fld[(j*NSRC+s)*6 +: 6] = 6'(t_src[j][s]);
        src_imm[j*NSRC+s] = t_imm[j][s];
      end
    end
  endtask

  // Decode the group as described: map, then scan backwards for the nearest writer.
  task automatic model_load();
    for (int j = 0; j < WID; j++) begin
      e_dst[j] = t_dvld[j] ? map_ref(t_dst[j], t_regx[j], int'(om)) : 0;
      for (int s = 0; s < NSRC; s++)
        e_src[j][s] = t_imm[j][s] ? 0 : map_ref(t_src[j][s], t_regx[j], int'(om));
    end
    for (int j = 0; j < WID; j++)
      for (int s = 0; s < NSRC; s++) begin
        e_dv[j][s] = 0; e_ds[j][s] = 0;
        if (e_src[j][s] != 0)
          for (int i = j - 1; i >= 0; i--)
            if (t_dvld[i] && e_dst[i] == e_src[j][s]) begin
              e_dv[j][s] = 1; e_ds[j][s] = i; break;
            end
      end
  endtask

  task automatic model_reset();
    e_valid = 0; e_stall = 0;
    for (int j = 0; j < WID; j++) begin
      e_dst[j] = 0;
      for (int s = 0; s < NSRC; s++) begin
        e_src[j][s] = 0; e_dv[j][s] = 0; e_ds[j][s] = 0;
      end
    end
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic cycle(input bit do_chk);
    bit rdy;
    logic [NS*AW-1:0]  p_src;
    logic [WID*AW-1:0] p_dst;
    logic [NS-1:0]     p_dv;
    logic [NS*SW-1:0]  p_ds;
    drive();
    #1;
    rdy = !e_valid || out_ready;
    if (do_chk) check("in_ready", 128'(in_ready), 128'(rdy));
    if (!rst_n) model_reset();
    else begin
      if (e_valid && !out_ready && e_stall < 65535) e_stall++;
      if (flush) e_valid = 0;
      else if (in_valid && rdy) begin model_load(); e_valid = 1; end
      else if (out_ready) e_valid = 0;
    end
    @(posedge clk); #1;
    if (do_chk) begin
      for (int j = 0; j < WID; j++) begin
        p_dst[j*AW +: AW] = AW'(e_dst[j]);
        for (int s = 0; s < NSRC; s++) begin
          p_src[(j*NSRC+s)*AW +: AW] = AW'(e_src[j][s]);
          p_dv[j*NSRC+s] = e_dv[j][s];
          p_ds[(j*NSRC+s)*SW +: SW] = SW'(e_ds[j][s]);
        end
      end
      check("out_valid", 128'(out_valid), 128'(e_valid));
      check("stall_cnt", 128'(stall_cnt), 128'(e_stall));
      check("src_reg", 128'(src_reg), 128'(p_src));
      check("dst_reg", 128'(dst_reg), 128'(p_dst));
      check("dep_vld", 128'(dep_vld), 128'(p_dv));
      check("dep_slot", 128'(dep_slot), 128'(p_ds));
    end
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 1; out_ready = 0; om = 2'd1;
    model_reset();
    rand_group();
    cycle(0);
    cycle(1);
    check("rst_outv", 128'(out_valid), 128'(0));
    rst_n = 1; in_valid = 0;
    cycle(1);
    check("rst_inrdy", 128'(in_ready), 128'(1));

    // Mapping corner cases.
    clear_group(); om = 2'd2; in_valid = 1; out_ready = 1;
    t_src[0][0] = 5;  t_imm[0][0] = 0; t_regx[0] = 1;
    t_src[1][0] = 63; t_imm[1][0] = 0; t_regx[1] = 0;
    t_src[2][0] = 63; t_imm[2][0] = 0; t_regx[2] = 1;
    cycle(1);
    check("map_69", 128'(src_reg[0 +: AW]), 128'(69));
    check("map_67", 128'(src_reg[3*AW +: AW]), 128'(67));
    check("map_127", 128'(src_reg[6*AW +: AW]), 128'(127));

    // Nearest earlier producer wins.
    clear_group(); om = 2'd0;
    t_dst[0] = 10; t_dvld[0] = 1; t_dst[2] = 10; t_dvld[2] = 1;
    t_src[3][0] = 10; t_imm[3][0] = 0; t_src[1][0] = 10; t_imm[1][0] = 0;
    cycle(1);
    check("dep3_vld", 128'(dep_vld[9]), 128'(1));
    check("dep3_slot", 128'(dep_slot[9*SW +: SW]), 128'(2));
    check("dep1_vld", 128'(dep_vld[3]), 128'(1));
    check("dep1_slot", 128'(dep_slot[3*SW +: SW]), 128'(0));
    clear_group();
    t_dst[0] = 0; t_dvld[0] = 1; t_src[1][0] = 0; t_imm[1][0] = 0;
    cycle(1);
    check("dep_r0", 128'(dep_vld[3]), 128'(0));

    // Back-to-back groups, then a three-cycle stall from a fresh reset.
    rand_group(); cycle(1); rand_group(); cycle(1);
    rst_n = 0; cycle(1); rst_n = 1;
    rand_group(); in_valid = 1; out_ready = 0; cycle(1);
    in_valid = 0; rand_group();
    repeat (3) cycle(1);
    check("stall3", 128'(stall_cnt), 128'(3));
    check("stall_inrdy", 128'(in_ready), 128'(0));

    // Flush with a held group and a new incoming group.
    in_valid = 1; flush = 1; rand_group(); cycle(1);
    check("flush_outv", 128'(out_valid), 128'(0));
    flush = 0; in_valid = 0; cycle(1);
    check("flush_nogrp", 128'(out_valid), 128'(0));

    // Randomised traffic including occasional flush and reset.
    for (int n = 0; n < 2000; n++) begin
      rst_n     = ($urandom_range(0, 60) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      om        = 2'($urandom_range(0, 3));
      rand_group();
      cycle(1);
    end

    // Saturate the stall counter, then reset it.
    rst_n = 1; flush = 0; in_valid = 1; out_ready = 1; rand_group(); cycle(1);
    in_valid = 0; out_ready = 0;
    repeat (65540) cycle(0);
    cycle(1);
    check("stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
    rst_n = 0; cycle(1);
    check("sat_rst_cnt", 128'(stall_cnt), 128'(0));
    check("sat_rst_outv", 128'(out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qupls_decode_src_pipe.md
QUPLS_DECODE_SRC_PIPE -- requirements
Module: Qupls_decode_src_pipe

Interface
REQ-001 Parameter WID, default 4: instruction slots decoded per cycle (1..8).
REQ-002 Parameter NSRC, default 3: source operands per slot (1..4).
REQ-003 Parameter AW, default 9: architectural register number width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous reset, active low.
REQ-006 om  in  2  operating mode, sampled on accept.
REQ-007 flush  in  1  discard held and incoming group.
REQ-008 in_valid  in  1  input group present.
REQ-009 in_ready  out  1  stage can accept this cycle.
REQ-010 src_fld  in  WID*NSRC*6  raw 6-bit source register fields.
REQ-011 src_imm  in  WID*NSRC  operand is immediate or unused.
REQ-012 dst_fld  in  WID*6  raw destination fields.
REQ-013 dst_vld  in  WID  slot writes a register.
REQ-014 regx  in  WID  per-slot extended register bank select.
REQ-015 out_valid  out  1  output group held.
REQ-016 out_ready  in  1  downstream accepts.
REQ-017 src_reg  out  WID*NSRC*AW  mapped source registers.
REQ-018 dst_reg  out  WID*AW  mapped destination registers.
REQ-019 dep_vld  out  WID*NSRC  source produced by an earlier slot in same group.
REQ-020 dep_slot  out  WID*NSRC*max(1,clog2(WID))  producing slot index.
REQ-021 stall_cnt  out  16  cycles with out_valid=1 and out_ready=0.

Function
REQ-022 Mapping: m = {0, regx[slot]?1:0, fld}; if m==63 then m = 65+om; result zero-extended to AW.
REQ-023 Source with src_imm set SHALL map to 0 and bypass the 63 alias.
REQ-024 Destination with dst_vld clear SHALL map to 0.
REQ-025 Register 0 SHALL never be a dependency source or producer.
REQ-026 dep_vld[j][s]=1 iff some slot i<j has dst_vld, mapped dst==mapped src, src!=0; dep_slot = greatest such i; otherwise dep_slot=0.
REQ-027 Mapping and dependency SHALL use the om value present in the accept cycle for the whole group.
REQ-028 in_ready = !out_valid | out_ready, combinational; flush does not affect in_ready.
REQ-029 Accept occurs when in_valid & in_ready & !flush; decoded group registered, out_valid=1 next cycle (latency 1).
REQ-030 When out_valid & !out_ready & !flush, all outputs SHALL hold stable.
REQ-031 out_valid & out_ready & no accept: out_valid=0 next cycle.
REQ-032 Simultaneous consume and accept: new group loaded, out_valid stays 1, no bubble.
REQ-033 flush=1: out_valid=0 next cycle regardless of in_valid/out_ready; incoming group dropped.
REQ-034 Data outputs SHALL hold last values while out_valid=0.
REQ-035 stall_cnt increments when out_valid & !out_ready, saturates at 16'hFFFF, never wraps; unaffected by flush.

Reset
REQ-036 rst_n=0 at a clock edge: out_valid=0, stall_cnt=0, src_reg/dst_reg/dep_vld/dep_slot=0.
REQ-037 Reset overrides flush and in_valid; no group accepted in a reset cycle; in_ready=1 after reset.
REQ-038 Reset mid-stall SHALL discard the held group.

Verification
REQ-039 WID=4; slot0 src_fld=5, regx=1, om=2 -> src_reg=69; src_fld=63, regx=0, om=2 -> 67; src_fld=63, regx=1 -> 127.
REQ-040 slot0 dst=10, slot2 dst=10, slot3 src=10 -> dep_vld=1, dep_slot=2; slot1 src=10 -> dep_slot=0, dep_vld=1; src=0 with slot0 dst=0 -> dep_vld=0.
REQ-041 Back-to-back groups A,B with out_ready=1 -> out_valid continuous, A then B on consecutive cycles.
REQ-042 out_ready=0 for 3 cycles with group held -> outputs stable, in_ready=0, stall_cnt=3.
REQ-043 flush asserted with in_valid=1 and held group -> next cycle out_valid=0, no group emitted.
REQ-044 Force stall_cnt to saturate (65540 stall cycles) -> reads 16'hFFFF; rst_n=0 one edge -> 0, out_valid=0.
